// File: rtl/reg_file_sb_pkg.sv
// Shared constants for the omega8 register file: clear-sequencer state
// encodings and default datapath geometry.
package reg_file_sb_pkg;

  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_RUN  = 1'b1
  } clr_state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;

endpackage

// File: rtl/reg_file_scoreboard.sv
// Per-register busy scoreboard: reserve sets, write or clear sequencer
// clears, reserve has priority. Exposes post-edge busy for two read ports.
module reg_file_scoreboard
  import reg_file_sb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_set,
  input  logic [ADDR_W-1:0]        i_set_address,
  input  logic                     i_wclr,
  input  logic [ADDR_W-1:0]        i_wclr_address,
  input  logic                     i_seq_clr,
  input  logic [ADDR_W-1:0]        i_seq_index,
  input  logic [ADDR_W-1:0]        i_r_address1,
  input  logic [ADDR_W-1:0]        i_r_address2,
  output logic [(1<<ADDR_W)-1:0]   o_busy_vec,
  output logic                     o_busy_next1,
  output logic                     o_busy_next2
);

  logic [(1<<ADDR_W)-1:0] busy;
  logic [(1<<ADDR_W)-1:0] busy_next;

  always_comb begin
    busy_next = busy;
    if (i_seq_clr) busy_next[i_seq_index] = 1'b0;
    if (i_wclr)    busy_next[i_wclr_address] = 1'b0;
    if (i_set)     busy_next[i_set_address] = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) busy <= '0;
    else       busy <= busy_next;
  end

  assign o_busy_vec   = busy;
  assign o_busy_next1 = busy_next[i_r_address1];
  assign o_busy_next2 = busy_next[i_r_address2];

endmodule

// File: rtl/reg_file_sb.sv
// Parametrised dual-read/single-write register file with optional zero
// register, write-to-read bypass, busy scoreboard and hardware clear sequencer.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_read,
  input  logic [ADDR_W-1:0]       i_r_address1,
  input  logic [ADDR_W-1:0]       i_r_address2,
  output logic [DATA_W-1:0]       o_data1,
  output logic [DATA_W-1:0]       o_data2,
  output logic                    o_busy1,
  output logic                    o_busy2,
  input  logic                    i_write,
  input  logic [ADDR_W-1:0]       i_w_address,
  input  logic [DATA_W-1:0]       i_data,
  input  logic                    i_reserve,
  input  logic [ADDR_W-1:0]       i_reserve_address,
  input  logic                    i_clear,
  output logic                    o_clear_busy,
  output logic [(1<<ADDR_W)-1:0]  o_busy_vec
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  clr_state_t        clr_state;
  logic [ADDR_W:0]   clr_cnt;
  logic [ADDR_W-1:0] clr_idx;
  logic              clr_run;
  logic              we;
  logic              rsv;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              bn1;
  logic              bn2;

  assign clr_run = (clr_state == CLR_RUN);
  assign clr_idx = clr_cnt[ADDR_W-1:0];
  assign we  = i_write   && !clr_run && !(ZERO_REG && i_w_address == '0);
  assign rsv = i_reserve && !clr_run && !(ZERO_REG && i_reserve_address == '0);

  // Bypass sees the register's post-edge value: 0 while being cleared, else the write data.
  always_comb begin
    rd1 = regs[i_r_address1];
    if (BYPASS && clr_run && i_r_address1 == clr_idx)  rd1 = '0;
    else if (BYPASS && we && i_r_address1 == i_w_address) rd1 = i_data;
    if (ZERO_REG && i_r_address1 == '0) rd1 = '0;
  end

  always_comb begin
    rd2 = regs[i_r_address2];
    if (BYPASS && clr_run && i_r_address2 == clr_idx)  rd2 = '0;
    else if (BYPASS && we && i_r_address2 == i_w_address) rd2 = i_data;
    if (ZERO_REG && i_r_address2 == '0) rd2 = '0;
  end

  reg_file_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_set          (rsv),
    .i_set_address  (i_reserve_address),
    .i_wclr         (we),
    .i_wclr_address (i_w_address),
    .i_seq_clr      (clr_run),
    .i_seq_index    (clr_idx),
    .i_r_address1   (i_r_address1),
    .i_r_address2   (i_r_address2),
    .o_busy_vec     (o_busy_vec),
    .o_busy_next1   (bn1),
    .o_busy_next2   (bn2)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (clr_run) begin
      regs[clr_idx] <= '0;
    end else if (we) begin
      regs[i_w_address] <= i_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_data1 <= '0;
      o_data2 <= '0;
      o_busy1 <= 1'b0;
      o_busy2 <= 1'b0;
    end else if (i_read) begin
      o_data1 <= rd1;
      o_data2 <= rd2;
      o_busy1 <= bn1;
      o_busy2 <= bn2;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      clr_state    <= CLR_IDLE;
      clr_cnt      <= '0;
      o_clear_busy <= 1'b0;
    end else begin
      case (clr_state)
        CLR_IDLE: begin
          if (i_clear) begin
            clr_state    <= CLR_RUN;
            clr_cnt      <= '0;
            o_clear_busy <= 1'b1;
          end
        end
        CLR_RUN: begin
          if (clr_cnt == (ADDR_W+1)'(DEPTH-1)) begin
            clr_state    <= CLR_IDLE;
            clr_cnt      <= '0;
            o_clear_busy <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: begin
          clr_state    <= CLR_IDLE;
          clr_cnt      <= '0;
          o_clear_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench: three instances (default, BYPASS=0, ZERO_REG=1) share one
// stimulus stream; expected values are hand-computed constants.
module tb_reg_file_sb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rd = 1'b0;
  logic [2:0] ra1 = '0, ra2 = '0, wa = '0, rsa = '0;
  logic       wr = 1'b0, rsv = 1'b0, clr = 1'b0;
  logic [7:0] wd = '0;

  logic [7:0] d1 [3];
  logic [7:0] d2 [3];
  logic       b1 [3];
  logic       b2 [3];
  logic       cb [3];
  logic [7:0] bv [3];

  int vectors = 0;
  int miscompares = 0;
  int n_high;

  always #5 clk = ~clk;

  reg_file_sb #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1'b0), .BYPASS(1'b1)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_read(rd), .i_r_address1(ra1), .i_r_address2(ra2),
    .o_data1(d1[0]), .o_data2(d2[0]), .o_busy1(b1[0]), .o_busy2(b2[0]),
    .i_write(wr), .i_w_address(wa), .i_data(wd), .i_reserve(rsv),
    .i_reserve_address(rsa), .i_clear(clr), .o_clear_busy(cb[0]), .o_busy_vec(bv[0]));

  reg_file_sb #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_read(rd), .i_r_address1(ra1), .i_r_address2(ra2),
    .o_data1(d1[1]), .o_data2(d2[1]), .o_busy1(b1[1]), .o_busy2(b2[1]),
    .i_write(wr), .i_w_address(wa), .i_data(wd), .i_reserve(rsv),
    .i_reserve_address(rsa), .i_clear(clr), .o_clear_busy(cb[1]), .o_busy_vec(bv[1]));

  reg_file_sb #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_read(rd), .i_r_address1(ra1), .i_r_address2(ra2),
    .o_data1(d1[2]), .o_data2(d2[2]), .o_busy1(b1[2]), .o_busy2(b2[2]),
    .i_write(wr), .i_w_address(wa), .i_data(wd), .i_reserve(rsv),
    .i_reserve_address(rsa), .i_clear(clr), .o_clear_busy(cb[2]), .o_busy_vec(bv[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rd = 1'b0; wr = 1'b0; rsv = 1'b0; clr = 1'b0;
  endtask

  initial begin
    // reset
    tick(); tick();
    chk("rst_d1", 32'(d1[0]), 32'h0);
    chk("rst_cb", 32'(cb[0]), 32'h0);
    rst = 1'b0;
    tick();
    rd = 1'b1; ra1 = 3'd3; ra2 = 3'd5;
    tick(); idle();
    chk("ro_d1", 32'(d1[0]), 32'h0);
    chk("ro_d2", 32'(d2[0]), 32'h0);
    chk("ro_bv", 32'(bv[0]), 32'h0);
    chk("ro_cb", 32'(cb[0]), 32'h0);

    // write then read, hold
    wr = 1'b1; wa = 3'd2; wd = 8'hA5;
    tick(); idle();
    rd = 1'b1; ra1 = 3'd2; ra2 = 3'd2;
    tick(); idle();
    chk("lat_d1", 32'(d1[0]), 32'hA5);
    chk("lat_d2", 32'(d2[0]), 32'hA5);
    ra1 = 3'd0; ra2 = 3'd1;
    tick();
    chk("hold_d1", 32'(d1[0]), 32'hA5);
    chk("hold_d2", 32'(d2[1]), 32'hA5);

    // same-edge bypass
    wr = 1'b1; wa = 3'd4; wd = 8'h3C; rd = 1'b1; ra1 = 3'd4; ra2 = 3'd2;
    tick(); idle();
    chk("byp1_d1", 32'(d1[0]), 32'h3C);
    chk("byp0_d1", 32'(d1[1]), 32'h00);
    chk("bypz_d1", 32'(d1[2]), 32'h3C);
    rd = 1'b1; ra1 = 3'd4;
    tick(); idle();
    chk("byp0_after", 32'(d1[1]), 32'h3C);

    // scoreboard
    rsv = 1'b1; rsa = 3'd6;
    tick(); idle();
    chk("sb_rsv_bv", 32'(bv[0]), 32'h40);
    rd = 1'b1; ra1 = 3'd6; ra2 = 3'd4;
    tick(); idle();
    chk("sb_b1", 32'(b1[0]), 32'h1);
    chk("sb_b2", 32'(b2[0]), 32'h0);
    wr = 1'b1; wa = 3'd6; wd = 8'h11;
    tick(); idle();
    chk("sb_wclr_bv", 32'(bv[0]), 32'h00);
    wr = 1'b1; wa = 3'd6; wd = 8'h22; rsv = 1'b1; rsa = 3'd6; rd = 1'b1; ra1 = 3'd6;
    tick(); idle();
    chk("sb_both_bv", 32'(bv[0]), 32'h40);
    chk("sb_both_b1", 32'(b1[0]), 32'h1);
    rd = 1'b1; ra1 = 3'd6;
    tick(); idle();
    chk("sb_both_d1", 32'(d1[1]), 32'h22);
    wr = 1'b1; wa = 3'd6; wd = 8'h22;
    tick(); idle();

    // zero register
    wr = 1'b1; wa = 3'd0; wd = 8'hFF; rsv = 1'b1; rsa = 3'd0;
    tick(); idle();
    rd = 1'b1; ra1 = 3'd0; ra2 = 3'd0;
    tick(); idle();
    chk("zr_d1", 32'(d1[2]), 32'h00);
    chk("zr_b1", 32'(b1[2]), 32'h0);
    chk("zr_bv", 32'(bv[2]), 32'h00);
    chk("nz_d1", 32'(d1[0]), 32'hFF);
    chk("nz_bv", 32'(bv[0]), 32'h01);
    wr = 1'b1; wa = 3'd0; wd = 8'h00;
    tick(); idle();

    // clear sequence
    for (int n = 0; n < 8; n++) begin
      wr = 1'b1; wa = 3'(n); wd = 8'(8'h10 + n);
      tick();
    end
    idle();
    rsv = 1'b1; rsa = 3'd1;
    tick(); idle();
    chk("pre_clr_bv", 32'(bv[0]), 32'h02);
    clr = 1'b1;
    tick(); idle();
    chk("clr_start", 32'(cb[0]), 32'h1);
    n_high = (cb[0] === 1'b1) ? 1 : 0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 3) begin wr = 1'b1; wa = 3'd0; wd = 8'h77; rsv = 1'b1; rsa = 3'd0; clr = 1'b1; end
      if (k == 4) begin rd = 1'b1; ra1 = 3'd3; ra2 = 3'd5; end
      if (k == 8) begin wr = 1'b1; wa = 3'd7; wd = 8'h77; end
      tick(); idle();
      if (k == 4) begin
        chk("run_byp1_d1", 32'(d1[0]), 32'h00);
        chk("run_byp0_d1", 32'(d1[1]), 32'h13);
        chk("run_d2", 32'(d2[0]), 32'h15);
      end
      if (cb[0] !== 1'b1) break;
      n_high++;
    end
    chk("clr_cycles", 32'(n_high), 32'd8);
    tick();
    chk("clr_idle", 32'(cb[0]), 32'h0);
    chk("clr_bv", 32'(bv[0]), 32'h00);
    for (int a = 0; a < 4; a++) begin
      rd = 1'b1; ra1 = 3'(a); ra2 = 3'(a + 4);
      tick(); idle();
      chk($sformatf("clr_d1_%0d", a), 32'(d1[0]), 32'h0);
      chk($sformatf("clr_d2_%0d", a + 4), 32'(d2[1]), 32'h0);
    end

    // reset in the middle of a clear
    wr = 1'b1; wa = 3'd5; wd = 8'h99;
    tick(); idle();
    rsv = 1'b1; rsa = 3'd2; rd = 1'b1; ra1 = 3'd5;
    tick(); idle();
    chk("mid_pre_d1", 32'(d1[0]), 32'h99);
    clr = 1'b1;
    tick(); idle();
    tick(); tick();
    chk("mid_running", 32'(cb[0]), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_cb", 32'(cb[0]), 32'h0);
    chk("mid_rst_bv", 32'(bv[0]), 32'h00);
    chk("mid_rst_d1", 32'(d1[0]), 32'h00);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_cb", 32'(cb[0]), 32'h0);
    rd = 1'b1; ra1 = 3'd5; ra2 = 3'd7;
    tick(); idle();
    chk("post_rst_d1", 32'(d1[0]), 32'h00);
    chk("post_rst_d2", 32'(d2[1]), 32'h00);
    tick();
    chk("post_rst_cb2", 32'(cb[0]), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
